// File: rtl/mic_pkg.sv
// Shared types and constants for the microphone frame packer.
package mic_pkg;

    localparam int N_MICS     = 4;
    localparam int I2S_SLOT_W = 32;

    // Mic index carried on tuser, in capture order.
    typedef enum logic [1:0] {
        MIC_LL = 2'd0,
        MIC_LH = 2'd1,
        MIC_RL = 2'd2,
        MIC_RH = 2'd3
    } mic_idx_t;

    typedef enum logic {
        SYNC     = 1'b0,
        ASSEMBLE = 1'b1
    } pkt_state_t;

endpackage

// File: rtl/mic_pkt_counter.sv
// Frame-within-packet counter; flags the final beat of each packet.
module mic_pkt_counter #(
    parameter int FRAMES_PER_PKT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic adv,
    output logic last
);

    localparam int CW = (FRAMES_PER_PKT > 1) ? $clog2(FRAMES_PER_PKT) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAMES_PER_PKT - 1);

    logic [CW-1:0] cnt;

    assign last = (cnt == LAST_IDX);

    // Advance once per output handshake, wrapping after the last beat.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (adv)
            cnt <= last ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/mic_frame_packer.sv
// Packs the interleaved LL/LH/RL/RH I2S word stream into 4-channel AXIS
// frames grouped into packets of FRAMES_PER_PKT beats.
// Optional MIC_FRAME_PACKER_STATS_EN adds saturating err_cnt / drop_cnt.
module mic_frame_packer
    import mic_pkg::*;
#(
    parameter int SAMPLE_W       = 24,
    parameter int FRAMES_PER_PKT = 256,
    parameter int CNT_W          = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [31:0]           s_axis_tdata,
    input  logic [1:0]            s_axis_tuser,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [4*SAMPLE_W-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  seq_err
`ifdef MIC_FRAME_PACKER_STATS_EN
    ,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [CNT_W-1:0]      drop_cnt
`endif
);

    pkt_state_t state, state_nxt;
    mic_idx_t   exp_idx, exp_nxt;

    logic [N_MICS-2:0][SAMPLE_W-1:0] slot;
    logic [SAMPLE_W-1:0]             sample;
    mic_idx_t                        idx;
    logic in_xfer, out_xfer, store, frame_done, err, cnt_last;
    logic unused_tdata;

    assign sample       = s_axis_tdata[I2S_SLOT_W-1 -: SAMPLE_W];
    assign unused_tdata = ^s_axis_tdata;
    assign idx          = mic_idx_t'(s_axis_tuser);

    // Only the completing RH word has to wait for the output register.
    assign s_axis_tready = !(state == ASSEMBLE && exp_idx == MIC_RH &&
                             m_axis_tvalid && !m_axis_tready);
    assign in_xfer  = s_axis_tvalid && s_axis_tready;
    assign out_xfer = m_axis_tvalid && m_axis_tready;

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= SYNC;
            exp_idx <= MIC_LL;
        end else begin
            state   <= state_nxt;
            exp_idx <= exp_nxt;
        end
    end

    // Ordering check and slot steering for each accepted word.
    always_comb begin
        state_nxt  = state;
        exp_nxt    = exp_idx;
        store      = 1'b0;
        frame_done = 1'b0;
        err        = 1'b0;
        if (in_xfer) begin
            case (state)
                SYNC: begin
                    if (idx == MIC_LL) begin
                        store     = 1'b1;
                        exp_nxt   = MIC_LH;
                        state_nxt = ASSEMBLE;
                    end
                end
                ASSEMBLE: begin
                    if (idx == exp_idx) begin
                        if (exp_idx == MIC_RH) begin
                            frame_done = 1'b1;
                            exp_nxt    = MIC_LL;
                        end else begin
                            store   = 1'b1;
                            exp_nxt = mic_idx_t'(exp_idx + 2'd1);
                        end
                    end else begin
                        err = 1'b1;
                        if (idx == MIC_LL) begin
                            store   = 1'b1;
                            exp_nxt = MIC_LH;
                        end else begin
                            state_nxt = SYNC;
                            exp_nxt   = MIC_LL;
                        end
                    end
                end
                default: state_nxt = SYNC;
            endcase
        end
    end

    // Staging slots for LL/LH/RL; a restart simply overwrites them in order.
    always_ff @(posedge aclk) begin
        if (areset) begin
            slot <= '0;
        end else begin
            for (int i = 0; i < N_MICS - 1; i++)
                if (store && s_axis_tuser == 2'(i))
                    slot[i] <= sample;
        end
    end

    // Output register: reloads on the hand-off edge so there is no bubble.
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            seq_err       <= 1'b0;
        end else begin
            seq_err <= err;
            if (frame_done) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= {sample, slot[2], slot[1], slot[0]};
            end else if (out_xfer) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    mic_pkt_counter #(
        .FRAMES_PER_PKT(FRAMES_PER_PKT)
    ) u_cnt (
        .clk (aclk),
        .rst (areset),
        .adv (out_xfer),
        .last(cnt_last)
    );

    assign m_axis_tlast = m_axis_tvalid && cnt_last;

`ifdef MIC_FRAME_PACKER_STATS_EN
    logic [2:0]     drop_inc;
    logic [CNT_W:0] drop_sum;

    // Words lost: strays seen while hunting for LL, plus the words of an
    // abandoned partial frame and the offending word unless it restarts one.
    always_comb begin
        drop_inc = 3'd0;
        if (in_xfer && state == SYNC && idx != MIC_LL)
            drop_inc = 3'd1;
        else if (err)
            drop_inc = {1'b0, exp_idx} + {2'b00, idx != MIC_LL};
    end

    assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(drop_inc);

    // Saturating statistics counters.
    always_ff @(posedge aclk) begin
        if (areset) begin
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (seq_err && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
            drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end
`endif

endmodule
